// File: rtl/atm_controller_if.sv
// atm_controller_if: bus between the card/keypad front end (master) and the
// ATM session controller (slave). clk and rst stay plain ports on the modules.
interface atm_controller_if #(
    parameter int ACC_W = 4,
    parameter int BAL_W = 16,
    parameter int PIN_W = 16
);
    logic             card_valid;
    logic [ACC_W-1:0] acc_num;
    logic [PIN_W-1:0] pin;
    logic             op_valid;
    logic [2:0]       operation;
    logic [BAL_W-1:0] amount;
    logic [PIN_W-1:0] new_pin;
    logic [BAL_W-1:0] balance;
    logic [2:0]       current_state;
    logic             done;
    logic [2:0]       err;

    modport master (
        output card_valid, acc_num, pin, op_valid, operation, amount, new_pin,
        input  balance, current_state, done, err
    );

    modport slave (
        input  card_valid, acc_num, pin, op_valid, operation, amount, new_pin,
        output balance, current_state, done, err
    );
endinterface

// File: rtl/atm_controller.sv
// atm_controller: ATM session FSM with per-account balance/PIN tables,
// PIN-retry lockout, MENU inactivity timeout and registered done/err results.
// Optional per-session withdraw cap: define ATM_DAILY_LIMIT_EN.
//
// state      | meaning
// WAITING    | no session, waiting for a card
// MENU       | authenticated, waiting for an operation or idle timeout
// BALANCE    | report table balance of the active account
// WITHDRAW   | debit latched amount if funds (and cap) allow
// DEPOSIT    | credit latched amount unless it overflows
// CHANGE_PIN | store latched new PIN
// AUTH       | check account number, lock flag and PIN
// LOCKED     | auth refused, waiting for card removal
module atm_controller #(
    parameter int NUM_ACCOUNTS  = 10,
    parameter int BAL_W         = 16,
    parameter int PIN_W         = 16,
    parameter int INIT_BAL      = 500,
    parameter int DEFAULT_PIN   = 1234,
    parameter int MAX_PIN_TRIES = 3,
    parameter int TIMEOUT_CYC   = 64,
    parameter int WD_LIMIT      = 300
) (
    input  logic            clk,
    input  logic            rst,
    atm_controller_if.slave bus
);
    localparam int ACC_W  = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
    localparam int TRY_W  = $clog2(MAX_PIN_TRIES + 1);
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [ACC_W:0]    NUM_ACC_L  = (ACC_W + 1)'(NUM_ACCOUNTS);
    localparam logic [BAL_W-1:0]  INIT_BAL_L = BAL_W'(INIT_BAL);
    localparam logic [PIN_W-1:0]  DEF_PIN_L  = PIN_W'(DEFAULT_PIN);
    localparam logic [TRY_W-1:0]  TRY_MAX_L  = TRY_W'(MAX_PIN_TRIES);
    localparam logic [IDLE_W-1:0] IDLE_LOAD  = IDLE_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] E_OK      = 3'd0;
    localparam logic [2:0] E_BAD_ACC = 3'd1;
    localparam logic [2:0] E_BAD_PIN = 3'd2;
    localparam logic [2:0] E_LOCKED  = 3'd3;
    localparam logic [2:0] E_INSUFF  = 3'd4;
    localparam logic [2:0] E_OVF     = 3'd5;
    localparam logic [2:0] E_TIMEOUT = 3'd6;
    localparam logic [2:0] E_LIMIT   = 3'd7;

    typedef enum logic [2:0] {
        S_WAITING    = 3'd0,
        S_MENU       = 3'd1,
        S_BALANCE    = 3'd2,
        S_WITHDRAW   = 3'd3,
        S_DEPOSIT    = 3'd4,
        S_CHANGE_PIN = 3'd5,
        S_AUTH       = 3'd6,
        S_LOCKED     = 3'd7
    } state_t;

    state_t state_q, state_d;

    logic [BAL_W-1:0]  bal_tab  [NUM_ACCOUNTS];
    logic [PIN_W-1:0]  pin_tab  [NUM_ACCOUNTS];
    logic [TRY_W-1:0]  try_tab  [NUM_ACCOUNTS];
    logic              lock_tab [NUM_ACCOUNTS];

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [BAL_W-1:0]  amt_q, amt_d;
    logic [PIN_W-1:0]  npin_q, npin_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [BAL_W-1:0]  balance_q, balance_d;
    logic              done_q, done_d;
    logic [2:0]        err_q, err_d;

    logic              bal_we, pin_we, try_we, lock_set;
    logic [BAL_W-1:0]  bal_wdata;
    logic [TRY_W-1:0]  try_wdata;

    logic              acc_ok;
    logic [BAL_W-1:0]  cur_bal;
    logic [TRY_W-1:0]  try_inc;
    logic [BAL_W:0]    dep_sum;
    logic              limit_hit;

    assign acc_ok  = {1'b0, bus.acc_num} < NUM_ACC_L;
    assign cur_bal = bal_tab[acc_q];
    assign try_inc = try_tab[bus.acc_num] + TRY_W'(1);
    assign dep_sum = {1'b0, cur_bal} + {1'b0, amt_q};

`ifdef ATM_DAILY_LIMIT_EN
    localparam logic [BAL_W:0] WD_LIMIT_L = (BAL_W + 1)'(WD_LIMIT);
    logic [BAL_W-1:0] wd_acc_q, wd_acc_d;
    logic [BAL_W:0]   wd_sum;
    assign wd_sum    = {1'b0, wd_acc_q} + {1'b0, amt_q};
    assign limit_hit = wd_sum > WD_LIMIT_L;

    // Session withdraw accumulator; only successful withdrawals add to it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wd_acc_q <= '0;
        else      wd_acc_q <= wd_acc_d;
    end
`else
    // Cap compiled out: the limit parameter is kept referenced but has no effect.
    logic unused_wd_limit;
    assign unused_wd_limit = |WD_LIMIT;
    assign limit_hit       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_WAITING;
        else      state_q <= state_d;
    end

    // Session registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            amt_q     <= '0;
            npin_q    <= '0;
            idle_q    <= '0;
            balance_q <= '0;
            done_q    <= 1'b0;
            err_q     <= E_OK;
        end else begin
            acc_q     <= acc_d;
            amt_q     <= amt_d;
            npin_q    <= npin_d;
            idle_q    <= idle_d;
            balance_q <= balance_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Account tables; reset restores every account to its factory values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                bal_tab[i]  <= INIT_BAL_L;
                pin_tab[i]  <= DEF_PIN_L;
                try_tab[i]  <= '0;
                lock_tab[i] <= 1'b0;
            end
        end else begin
            if (bal_we)   bal_tab[acc_q]        <= bal_wdata;
            if (pin_we)   pin_tab[acc_q]        <= npin_q;
            if (try_we)   try_tab[bus.acc_num]  <= try_wdata;
            if (lock_set) lock_tab[bus.acc_num] <= 1'b1;
        end
    end

    // Next state, table updates and result codes.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        amt_d     = amt_q;
        npin_d    = npin_q;
        idle_d    = IDLE_LOAD;
        balance_d = balance_q;
        done_d    = 1'b0;
        err_d     = err_q;
        bal_we    = 1'b0;
        bal_wdata = cur_bal;
        pin_we    = 1'b0;
        try_we    = 1'b0;
        try_wdata = try_inc;
        lock_set  = 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
        wd_acc_d  = wd_acc_q;
`endif
        case (state_q)
            S_WAITING: begin
                balance_d = '0;
`ifdef ATM_DAILY_LIMIT_EN
                wd_acc_d  = '0;
`endif
                if (bus.card_valid) state_d = S_AUTH;
            end
            S_AUTH: begin
                done_d = 1'b1;
                if (!acc_ok) begin
                    err_d   = E_BAD_ACC;
                    state_d = S_LOCKED;
                end else if (lock_tab[bus.acc_num]) begin
                    err_d   = E_LOCKED;
                    state_d = S_LOCKED;
                end else if (pin_tab[bus.acc_num] == bus.pin) begin
                    err_d     = E_OK;
                    try_we    = 1'b1;
                    try_wdata = '0;
                    acc_d     = bus.acc_num;
                    state_d   = S_MENU;
                end else begin
                    err_d    = E_BAD_PIN;
                    try_we   = 1'b1;
                    lock_set = try_inc >= TRY_MAX_L;
                    state_d  = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (!bus.card_valid) state_d = S_WAITING;
            end
            S_MENU: begin
                if (!bus.card_valid || (bus.op_valid && bus.operation == 3'd5)) begin
                    state_d   = S_WAITING;
                    done_d    = 1'b1;
                    err_d     = E_OK;
                    balance_d = '0;
                end else if (bus.op_valid) begin
                    // operands are only valid with the strobe, so hold them for the op state
                    amt_d  = bus.amount;
                    npin_d = bus.new_pin;
                    case (bus.operation)
                        3'd1:    state_d = S_BALANCE;
                        3'd2:    state_d = S_WITHDRAW;
                        3'd3:    state_d = S_DEPOSIT;
                        3'd4:    state_d = S_CHANGE_PIN;
                        default: state_d = S_MENU;
                    endcase
                end else if (idle_q == '0) begin
                    state_d   = S_WAITING;
                    done_d    = 1'b1;
                    err_d     = E_TIMEOUT;
                    balance_d = '0;
                end else begin
                    idle_d = idle_q - IDLE_W'(1);
                end
            end
            S_BALANCE: begin
                state_d   = S_MENU;
                done_d    = 1'b1;
                err_d     = E_OK;
                balance_d = cur_bal;
            end
            S_WITHDRAW: begin
                state_d   = S_MENU;
                done_d    = 1'b1;
                err_d     = E_OK;
                balance_d = cur_bal;
                if (limit_hit) begin
                    err_d = E_LIMIT;
                end else if (amt_q > cur_bal) begin
                    err_d = E_INSUFF;
                end else begin
                    bal_we    = 1'b1;
                    bal_wdata = cur_bal - amt_q;
                    balance_d = cur_bal - amt_q;
`ifdef ATM_DAILY_LIMIT_EN
                    wd_acc_d  = wd_sum[BAL_W-1:0];
`endif
                end
            end
            S_DEPOSIT: begin
                state_d   = S_MENU;
                done_d    = 1'b1;
                err_d     = E_OK;
                balance_d = cur_bal;
                if (dep_sum[BAL_W]) begin
                    err_d = E_OVF;
                end else begin
                    bal_we    = 1'b1;
                    bal_wdata = dep_sum[BAL_W-1:0];
                    balance_d = dep_sum[BAL_W-1:0];
                end
            end
            S_CHANGE_PIN: begin
                state_d = S_MENU;
                done_d  = 1'b1;
                err_d   = E_OK;
                pin_we  = 1'b1;
            end
        endcase
    end

    assign bus.balance       = balance_q;
    assign bus.current_state = state_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_atm_controller.sv
// tb_atm_controller: directed scenarios plus randomized sessions for
// atm_controller, checked against a transaction-level account model.
module tb_atm_controller;
    localparam int NACC    = 10;
    localparam int ACC_W   = 4;
    localparam int BAL_W   = 16;
    localparam int PIN_W   = 16;
    localparam int TIMEOUT = 64;
    localparam int BAL_MAX = 65535;
    localparam int CAP     = 300;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_mis = 0;

    atm_controller_if #(.ACC_W(ACC_W), .BAL_W(BAL_W), .PIN_W(PIN_W)) bus ();

    atm_controller #(
        .NUM_ACCOUNTS(NACC), .BAL_W(BAL_W), .PIN_W(PIN_W), .INIT_BAL(500),
        .DEFAULT_PIN(1234), .MAX_PIN_TRIES(3), .TIMEOUT_CYC(TIMEOUT), .WD_LIMIT(CAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // account model
    int unsigned m_bal  [NACC];
    int unsigned m_pin  [NACC];
    int          m_tries[NACC];
    bit          m_lock [NACC];
    int unsigned m_wd;
    int unsigned m_bal_out;
    int          m_acc;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NACC; i++) begin
            m_bal[i]   = 500;
            m_pin[i]   = 1234;
            m_tries[i] = 0;
            m_lock[i]  = 1'b0;
        end
        m_wd      = 0;
        m_bal_out = 0;
        m_acc     = 0;
    endfunction

    function automatic int model_auth(input int a, input int unsigned p);
        if (a >= NACC) return 1;
        if (m_lock[a]) return 3;
        if (p == m_pin[a]) begin
            m_tries[a] = 0;
            m_acc      = a;
            m_wd       = 0;
            return 0;
        end
        m_tries[a]++;
        if (m_tries[a] >= 3) m_lock[a] = 1'b1;
        return 2;
    endfunction

    function automatic int model_op(input int op, input int unsigned amt, input int unsigned np);
        int r;
        r = 0;
        case (op)
            1: m_bal_out = m_bal[m_acc];
            2: begin
`ifdef ATM_DAILY_LIMIT_EN
                if (m_wd + amt > CAP) r = 7;
                else
`endif
                if (amt > m_bal[m_acc]) r = 4;
                else begin
                    m_bal[m_acc] -= amt;
                    m_wd         += amt;
                end
                m_bal_out = m_bal[m_acc];
            end
            3: begin
                if (m_bal[m_acc] + amt > BAL_MAX) r = 5;
                else m_bal[m_acc] += amt;
                m_bal_out = m_bal[m_acc];
            end
            4: m_pin[m_acc] = np;
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.done && cyc < budget);
        if (!bus.done) check_val("done_wait_expired", 0, 1);
    endtask

    task automatic do_auth(input int a, input int unsigned p, output bit ok);
        int e;
        int cyc;
        e = model_auth(a, p);
        bus.card_valid = 1'b1;
        bus.acc_num    = ACC_W'(a);
        bus.pin        = PIN_W'(p);
        wait_done(6, cyc);
        check_val("auth_latency", cyc, 2);
        check_val("auth_err", 32'(bus.err), e);
        check_val("auth_state", 32'(bus.current_state), (e == 0) ? 1 : 7);
        ok = (e == 0);
        if (!ok) begin
            bus.card_valid = 1'b0;
            tick();
            check_val("locked_release_state", 32'(bus.current_state), 0);
        end
    endtask

    task automatic do_op(input int op, input int unsigned amt, input int unsigned np);
        int e;
        int cyc;
        e = model_op(op, amt, np);
        bus.op_valid  = 1'b1;
        bus.operation = 3'(op);
        bus.amount    = BAL_W'(amt);
        bus.new_pin   = PIN_W'(np);
        tick();
        bus.op_valid = 1'b0;
        bus.amount   = '0;
        bus.new_pin  = '0;
        check_val("op_state", 32'(bus.current_state), op + 1);
        wait_done(4, cyc);
        check_val("op_latency", cyc, 1);
        check_val("op_err", 32'(bus.err), e);
        check_val("op_balance", 32'(bus.balance), m_bal_out);
        check_val("op_back_to_menu", 32'(bus.current_state), 1);
    endtask

    task automatic do_exit(input bit by_card);
        if (by_card) bus.card_valid = 1'b0;
        else begin
            bus.op_valid  = 1'b1;
            bus.operation = 3'd5;
        end
        tick();
        bus.op_valid   = 1'b0;
        bus.card_valid = 1'b0;
        m_bal_out      = 0;
        check_val("exit_done", 32'(bus.done), 1);
        check_val("exit_err", 32'(bus.err), 0);
        check_val("exit_state", 32'(bus.current_state), 0);
        check_val("exit_balance", 32'(bus.balance), 0);
    endtask

    task automatic do_ignored(input int op);
        bus.op_valid  = 1'b1;
        bus.operation = 3'(op);
        tick();
        bus.op_valid = 1'b0;
        check_val("ignored_op_state", 32'(bus.current_state), 1);
        tick();
        check_val("ignored_op_done", 32'(bus.done), 0);
    endtask

    task automatic idle(input int n);
        int spur;
        spur = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.done) spur++;
        end
        check_val("idle_no_done", spur, 0);
    endtask

    task automatic do_timeout();
        int cyc;
        wait_done(TIMEOUT + 8, cyc);
        bus.card_valid = 1'b0;
        m_bal_out      = 0;
        check_val("timeout_cycles", cyc, TIMEOUT);
        check_val("timeout_err", 32'(bus.err), 6);
        check_val("timeout_state", 32'(bus.current_state), 0);
        check_val("timeout_balance", 32'(bus.balance), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          a;
        int          op;
        int          e;
        int          nops;
        int unsigned p;
        int unsigned amt;
        int unsigned np;

        rst            = 1'b0;
        bus.card_valid = 1'b0;
        bus.acc_num    = '0;
        bus.pin        = '0;
        bus.op_valid   = 1'b0;
        bus.operation  = '0;
        bus.amount     = '0;
        bus.new_pin    = '0;
        model_reset();
        repeat (2) tick();
        check_val("reset_state", 32'(bus.current_state), 0);
        check_val("reset_balance", 32'(bus.balance), 0);
        check_val("reset_done", 32'(bus.done), 0);
        check_val("reset_err", 32'(bus.err), 0);
        rst = 1'b1;
        tick();
        check_val("idle_waiting", 32'(bus.current_state), 0);

        // basic session, withdraw and insufficient funds, ignored opcodes
        do_auth(3, 1234, ok);
        do_op(1, 0, 0);
        do_op(2, 200, 0);
        do_op(2, 400, 0);
        do_ignored(6);
        do_ignored(0);
        do_ignored(7);
        do_exit(1'b0);

        // lockout after three bad PINs, neighbour account unaffected, bad account number
        repeat (3) do_auth(5, 1111, ok);
        do_auth(5, 1234, ok);
        do_auth(6, 1234, ok);
        do_exit(1'b1);
        do_auth(12, 1234, ok);

        // deposit overflow, PIN change, re-auth with new and old PIN
        do_auth(2, 1234, ok);
        do_op(3, 65500, 0);
        do_op(4, 0, 42);
        do_exit(1'b0);
        do_auth(2, 42, ok);
        do_exit(1'b1);
        do_auth(2, 1234, ok);

        // balance edges: fill to max, overflow by one, zero and full withdraw
        do_auth(4, 1234, ok);
        do_op(3, 65035, 0);
        do_op(3, 1, 0);
        do_op(2, 0, 0);
        do_op(2, 65535, 0);
        do_op(2, 1, 0);
        do_exit(1'b0);

        // idle 63 cycles then an op is still accepted; then full timeout
        do_auth(1, 1234, ok);
        idle(TIMEOUT - 1);
        do_op(1, 0, 0);
        do_timeout();

        // card removed during an op: op completes, then the session ends
        do_auth(8, 1234, ok);
        e = model_op(3, 10, 0);
        bus.op_valid  = 1'b1;
        bus.operation = 3'd3;
        bus.amount    = BAL_W'(10);
        tick();
        bus.op_valid   = 1'b0;
        bus.card_valid = 1'b0;
        tick();
        check_val("drop_op_done", 32'(bus.done), 1);
        check_val("drop_op_err", 32'(bus.err), e);
        check_val("drop_op_balance", 32'(bus.balance), m_bal_out);
        tick();
        m_bal_out = 0;
        check_val("drop_exit_done", 32'(bus.done), 1);
        check_val("drop_exit_state", 32'(bus.current_state), 0);

        // reset asserted while in WITHDRAW restores all tables
        do_auth(0, 1234, ok);
        bus.op_valid  = 1'b1;
        bus.operation = 3'd2;
        bus.amount    = BAL_W'(100);
        tick();
        bus.op_valid = 1'b0;
        check_val("midop_state", 32'(bus.current_state), 3);
        rst            = 1'b0;
        bus.card_valid = 1'b0;
        #1;
        check_val("midop_rst_state", 32'(bus.current_state), 0);
        check_val("midop_rst_balance", 32'(bus.balance), 0);
        check_val("midop_rst_done", 32'(bus.done), 0);
        tick();
        rst = 1'b1;
        model_reset();
        do_auth(5, 1234, ok);
        do_op(1, 0, 0);
        do_exit(1'b1);
        do_auth(2, 1234, ok);
        do_exit(1'b0);
        do_auth(0, 1234, ok);
        do_op(1, 0, 0);
        do_exit(1'b0);

        // per-session withdraw cap (err 7 only when the cap is built in)
        do_auth(7, 1234, ok);
        do_op(2, 200, 0);
        do_op(2, 150, 0);
        do_exit(1'b0);

        // randomized sessions
        for (int s = 0; s < 40; s++) begin
            a = $urandom_range(0, 11);
            if (a < NACC && $urandom_range(0, 4) != 0) p = m_pin[a];
            else p = $urandom_range(0, 9999);
            do_auth(a, p, ok);
            if (ok) begin
                nops = $urandom_range(1, 5);
                for (int k = 0; k < nops; k++) begin
                    op  = $urandom_range(1, 4);
                    amt = 0;
                    np  = 0;
                    if (op == 2) amt = $urandom_range(0, 400);
                    if (op == 3) amt = ($urandom_range(0, 7) == 0) ? $urandom_range(60000, 65535)
                                                                   : $urandom_range(0, 300);
                    if (op == 4) np = $urandom_range(0, 9999);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 50));
                    do_op(op, amt, np);
                end
                do_exit(1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
